// File: rtl/logic_gate_pkg.sv
// Shared op-code constants and FSM state encoding for the gate sweep block.
package logic_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_XNOR;
    endfunction

endpackage

// File: rtl/logic_gate_n.sv
// N-input combinational gate; illegal op codes yield 0.
module logic_gate_n
    import logic_gate_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [N_IN-1:0] a,
    input  logic [2:0]      op,
    output logic            y
);

    always_comb begin
        y = 1'b0;
        case (op)
            OP_AND:  y = &a;
            OP_OR:   y = |a;
            OP_XOR:  y = ^a;
            OP_NAND: y = ~&a;
            OP_NOR:  y = ~|a;
            OP_XNOR: y = ~^a;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/logic_gate_sweep.sv
// Registered N-input gate with an on-demand exhaustive truth-table sweep.
module logic_gate_sweep
    import logic_gate_pkg::*;
#(
    parameter  int N_IN = 3,
    localparam int TT_W = 2**N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] din,
    input  logic [2:0]      op,
    input  logic            start,
    output logic            dout,
    output logic            dout_vld,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt,
    output logic            tt_vld,
    output logic            err
);

    localparam logic [N_IN-1:0] CNT_LAST = '1;

    state_e          state, state_nxt;
    logic [N_IN-1:0] cnt;
    logic [2:0]      op_q;
    logic [N_IN-1:0] gate_a;
    logic [2:0]      gate_op;
    logic            f;

    // One gate instance serves both modes: live operands in IDLE, the counter while sweeping.
    always_comb begin
        gate_a  = (state == SWEEP) ? cnt : din;
        gate_op = (state == IDLE)  ? op  : op_q;
    end

    logic_gate_n #(.N_IN(N_IN)) u_gate (
        .a  (gate_a),
        .op (gate_op),
        .y  (f)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        err       = !op_legal(gate_op);
        case (state)
            IDLE:    if (start) state_nxt = SWEEP;
            SWEEP: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            op_q     <= '0;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
            tt       <= '0;
            tt_vld   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dout     <= f;
                    // The start edge hands the output over to the sweep, so it is not flagged.
                    dout_vld <= !start;
                    if (start) begin
                        op_q   <= op;
                        cnt    <= '0;
                        tt     <= '0;
                        tt_vld <= 1'b0;
                    end
                end
                SWEEP: begin
                    tt[cnt]  <= f;
                    dout     <= f;
                    dout_vld <= 1'b0;
                    if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
                end
                DONE: begin
                    tt_vld   <= 1'b1;
                    dout_vld <= 1'b0;
                end
                default: dout_vld <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_gate_sweep.sv
// Scoreboard bench for logic_gate_sweep with N_IN=3 and hand-computed vectors.
module tb_logic_gate_sweep;
    import logic_gate_pkg::*;

    localparam int N_IN = 3;
    localparam int TT_W = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_IN-1:0] din;
    logic [2:0]      op;
    logic            start;
    logic            dout, dout_vld, busy, done, tt_vld, err;
    logic [TT_W-1:0] tt;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic tt_vld_d = 1'b0;

    logic       exp_dout_q[$];
    logic [7:0] exp_tt_q[$];

    always #5 clk = ~clk;

    logic_gate_sweep #(.N_IN(N_IN)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .op       (op),
        .start    (start),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy),
        .done     (done),
        .tt       (tt),
        .tt_vld   (tt_vld),
        .err      (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
            if (dout_vld && exp_dout_q.size() > 0)
                check("dout", {31'd0, dout}, {31'd0, exp_dout_q.pop_front()});
            if (tt_vld && !tt_vld_d) begin
                if (exp_tt_q.size() > 0)
                    check("tt", {24'd0, tt}, {24'd0, exp_tt_q.pop_front()});
                else begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL tt_vld_unexpected: got tt_vld=1 tt=%0h, expected no completion", tt);
                end
            end
            tt_vld_d = tt_vld;
        end
    end

    task automatic idle_step(input logic [2:0] d, input logic [2:0] o, input logic e);
        @(negedge clk);
        din   = d;
        op    = o;
        start = 1'b0;
        exp_dout_q.push_back(e);
    endtask

    task automatic run_sweep(input logic [2:0] o, input logic [7:0] exp_tt,
                             input logic exp_err, input bit restart);
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        op    = o;
        start = 1'b1;
        exp_tt_q.push_back(exp_tt);
        @(negedge clk);
        start = 1'b0;
        op    = o ^ 3'd7;
        for (int i = 1; i <= TT_W; i++) begin
            check("busy_sweep", {31'd0, busy}, 32'd1);
            check("done_early", {31'd0, done}, 32'd0);
            check("err_sweep", {31'd0, err}, {31'd0, exp_err});
            if (i == 2) check("dout_vld_sweep", {31'd0, dout_vld}, 32'd0);
            if (restart && i == 3) begin
                start = 1'b1;
                op    = OP_OR;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("err_done", {31'd0, err}, {31'd0, exp_err});
        @(negedge clk);
        check("done_after", {31'd0, done}, 32'd0);
        check("tt_vld_after", {31'd0, tt_vld}, 32'd1);
        check("done_count", done_cnt, d0 + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0] d;
        logic [2:0] o;
        logic       e;
    } ivec_t;

    typedef struct {
        logic [2:0] o;
        logic [7:0] t;
        logic       e;
    } svec_t;

    ivec_t ivecs[$];
    svec_t svecs[$];

    initial begin
        int d0;
        rst   = 1'b1;
        din   = '0;
        op    = OP_AND;
        start = 1'b0;

        ivecs = '{
            '{3'd0, OP_AND, 1'b0}, '{3'd1, OP_AND, 1'b0}, '{3'd2, OP_AND, 1'b0},
            '{3'd3, OP_AND, 1'b0}, '{3'd4, OP_AND, 1'b0}, '{3'd5, OP_AND, 1'b0},
            '{3'd6, OP_AND, 1'b0}, '{3'd7, OP_AND, 1'b1},
            '{3'd0, OP_OR, 1'b0},  '{3'd4, OP_OR, 1'b1},
            '{3'd3, OP_XOR, 1'b0}, '{3'd7, OP_XOR, 1'b1},
            '{3'd7, OP_NAND, 1'b0}, '{3'd5, OP_NAND, 1'b1},
            '{3'd0, OP_NOR, 1'b1},  '{3'd2, OP_NOR, 1'b0},
            '{3'd6, OP_XNOR, 1'b1}, '{3'd1, OP_XNOR, 1'b0},
            '{3'd7, 3'd6, 1'b0}
        };
        svecs = '{
            '{OP_AND, 8'h80, 1'b0}, '{OP_OR, 8'hFE, 1'b0}, '{OP_XOR, 8'h96, 1'b0},
            '{OP_NAND, 8'h7F, 1'b0}, '{OP_NOR, 8'h01, 1'b0}, '{OP_XNOR, 8'h69, 1'b0},
            '{3'd6, 8'h00, 1'b1}
        };

        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dout", {31'd0, dout}, 32'd0);
        check("rst_dout_vld", {31'd0, dout_vld}, 32'd0);
        check("rst_tt", {24'd0, tt}, 32'd0);
        check("rst_tt_vld", {31'd0, tt_vld}, 32'd0);
        rst = 1'b0;

        foreach (ivecs[i]) idle_step(ivecs[i].d, ivecs[i].o, ivecs[i].e);
        #1;
        check("err_idle_op6", {31'd0, err}, 32'd1);
        idle_step(3'd7, OP_AND, 1'b1);
        #1;
        check("err_idle_op0", {31'd0, err}, 32'd0);

        foreach (svecs[i]) run_sweep(svecs[i].o, svecs[i].t, svecs[i].e, 1'b0);

        // Start re-pulsed and op changed mid-sweep: latched AND must govern.
        run_sweep(OP_AND, 8'h80, 1'b0, 1'b1);

        // Reset in sweep cycle 4 aborts with everything cleared at once.
        @(negedge clk);
        op    = OP_AND;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        d0  = done_cnt;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_dout", {31'd0, dout}, 32'd0);
        check("abort_dout_vld", {31'd0, dout_vld}, 32'd0);
        check("abort_tt", {24'd0, tt}, 32'd0);
        check("abort_tt_vld", {31'd0, tt_vld}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        din = 3'd7;
        op  = OP_AND;
        exp_dout_q.push_back(1'b1);
        idle_step(3'd6, OP_AND, 1'b0);
        repeat (12) @(negedge clk);
        check("abort_no_done", done_cnt, d0);
        run_sweep(OP_XOR, 8'h96, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("dout_queue_drained", exp_dout_q.size(), 0);
        check("tt_queue_drained", exp_tt_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
